// File: rtl/rr_packet_arbiter_if.sv
// rr_packet_arbiter_if: requester-side and datapath-side handshake bundle.
// master = arbiter view, slave = environment (requesters + datapath) view.
interface rr_packet_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
);
  localparam int SRC_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req_valid_i;
  logic [N_REQ-1:0]       req_last_i;
  logic [N_REQ*WIDTH-1:0] req_data_i;
  logic [N_REQ-1:0]       req_ready_o;
  logic                   out_valid_o;
  logic [WIDTH-1:0]       out_data_o;
  logic                   out_last_o;
  logic [SRC_W-1:0]       out_src_o;
  logic                   out_ready_i;

  modport master (
    input  req_valid_i,
    input  req_last_i,
    input  req_data_i,
    input  out_ready_i,
    output req_ready_o,
    output out_valid_o,
    output out_data_o,
    output out_last_o,
    output out_src_o
  );

  modport slave (
    output req_valid_i,
    output req_last_i,
    output req_data_i,
    output out_ready_i,
    input  req_ready_o,
    input  out_valid_o,
    input  out_data_o,
    input  out_last_o,
    input  out_src_o
  );
endinterface

// File: rtl/rr_packet_arbiter.sv
// rr_packet_arbiter: packet-granular round-robin arbiter, registered output.
// Ports: clk_i, rst_i (sync, active-high), bus (rr_packet_arbiter_if.master),
//   err_len_o (sticky truncation flag), grant_cnt_o (only with ARB_STATS_EN).
// Optional feature macro: ARB_STATS_EN (per-requester saturating grant counters).
module rr_packet_arbiter #(
  parameter int WIDTH     = 8,
  parameter int N_REQ     = 4,
  parameter int MAX_BEATS = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  rr_packet_arbiter_if.master  bus,
`ifdef ARB_STATS_EN
  output logic [N_REQ*CNT_WIDTH-1:0] grant_cnt_o,
`endif
  output logic                 err_len_o
);

  localparam int SRC_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;
  localparam int MB_W  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [MB_W-1:0]  BEAT_CAP = MB_W'(MAX_BEATS - 1);
  localparam logic [SRC_W-1:0] SRC_TOP  = SRC_W'(N_REQ - 1);

  if (WIDTH < 1 || N_REQ < 2 || CNT_WIDTH < 1 || MAX_BEATS < 0)
  begin : g_bad_cfg
    $error("rr_packet_arbiter: illegal parameter set");
  end

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t            state_q, state_d;
  logic [SRC_W-1:0]  gnt_q, gnt_d;
  logic [SRC_W-1:0]  ptr_q, ptr_d;
  logic [MB_W-1:0]   bcnt_q, bcnt_d;
  logic              ov_q, ov_d;
  logic [WIDTH-1:0]  od_q, od_d;
  logic              ol_q, ol_d;
  logic [SRC_W-1:0]  os_q, os_d;
  logic              err_q, err_d;

  logic [SRC_W-1:0]  pick;
  logic              any_req;
  logic [N_REQ-1:0]  rdy_vec;
  logic              slot_free;
  logic              fire;
  logic              cap_hit;
  logic              last_eff;
  logic [WIDTH-1:0]  beat;
  logic [SRC_W-1:0]  ptr_nxt;

  // Scan from the far end back toward the pointer so the requester
  // nearest at/after the pointer is the one left in pick.
  always_comb begin
    int idx;
    idx     = 0;
    pick    = '0;
    any_req = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (bus.req_valid_i[idx]) begin
        pick    = SRC_W'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign beat    = bus.req_data_i[int'(gnt_q)*WIDTH +: WIDTH];
  assign ptr_nxt = (gnt_q == SRC_TOP) ? '0 : gnt_q + 1'b1;
  assign cap_hit = (MAX_BEATS > 0) && (bcnt_q == BEAT_CAP);
  assign last_eff = bus.req_last_i[gnt_q] || cap_hit;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    bcnt_d    = bcnt_q;
    ov_d      = ov_q;
    od_d      = od_q;
    ol_d      = ol_q;
    os_d      = os_q;
    err_d     = err_q;
    rdy_vec   = '0;
    slot_free = 1'b0;
    fire      = 1'b0;

    // A presented beat leaves the register when the datapath takes it;
    // a newly accepted beat below overrides this.
    if (ov_q && bus.out_ready_i) ov_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d   = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        slot_free = !ov_q || bus.out_ready_i;
        if (slot_free) rdy_vec[gnt_q] = 1'b1;
        fire = slot_free && bus.req_valid_i[gnt_q];
        if (fire) begin
          ov_d = 1'b1;
          od_d = beat;
          ol_d = last_eff;
          os_d = gnt_q;
          if (cap_hit && !bus.req_last_i[gnt_q]) err_d = 1'b1;
          if (last_eff) begin
            ptr_d   = ptr_nxt;
            bcnt_d  = '0;
            state_d = IDLE;
          end else if (MAX_BEATS > 0) begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      bcnt_q  <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ol_q    <= 1'b0;
      os_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ol_q    <= ol_d;
      os_q    <= os_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready_o = rdy_vec;
  assign bus.out_valid_o = ov_q;
  assign bus.out_data_o  = od_q;
  assign bus.out_last_o  = ol_q;
  assign bus.out_src_o   = os_q;
  assign err_len_o       = err_q;

`ifdef ARB_STATS_EN
  logic [CNT_WIDTH-1:0] gcnt_q [N_REQ];
  logic                 grant_now;

  assign grant_now = (state_q == IDLE) && any_req;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < N_REQ; r++) gcnt_q[r] <= '0;
    end else if (grant_now) begin
      for (int r = 0; r < N_REQ; r++) begin
        if (pick == SRC_W'(r) && gcnt_q[r] != '1)
          gcnt_q[r] <= gcnt_q[r] + 1'b1;
      end
    end
  end

  for (genvar r = 0; r < N_REQ; r++) begin : g_cnt
    assign grant_cnt_o[r*CNT_WIDTH +: CNT_WIDTH] = gcnt_q[r];
  end
`endif

endmodule
